// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbiter sharing one registered-read memory between instruction fetch and data access
module mem_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_ireq,
  input  logic [11:0] w_iaddr,
  output logic        r_iack,
  output logic [31:0] r_irdata,
  input  logic        w_dreq,
  input  logic        w_dwe,
  input  logic [11:0] w_daddr,
  input  logic [31:0] w_dwdata,
  output logic        r_dack,
  output logic [31:0] r_drdata,
  output logic [11:0] r_maddr,
  output logic        r_mwe,
  output logic [31:0] r_mwdata,
  input  logic [31:0] w_mrdata,
  output logic        r_busy
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state, state_nxt;
  logic        owner_d;
  logic        owner_wr;
  logic [2:0]  cnt;
  logic [3:0]  starve_cnt;
  logic        ireq_m, dreq_m, grant, grant_d, done;

  always_ff @(posedge w_clk) begin
    if (w_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant) state_nxt = S_WAIT;
      S_WAIT:  if (cnt == 3'd0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A requester still holds req during its own ack cycle, so that req is masked.
  always_comb begin
    ireq_m  = w_ireq & ~r_iack;
    dreq_m  = w_dreq & ~r_dack;
    grant_d = dreq_m & ~(ireq_m & (starve_cnt == 4'(STARVE_MAX)));
    grant   = (state == S_IDLE) & (ireq_m | dreq_m);
    done    = (state == S_WAIT) & (cnt == 3'd0);
    r_busy  = (state != S_IDLE);
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      owner_d    <= 1'b0;
      owner_wr   <= 1'b0;
      cnt        <= 3'd0;
      starve_cnt <= 4'd0;
      r_iack     <= 1'b0;
      r_dack     <= 1'b0;
      r_irdata   <= 32'd0;
      r_drdata   <= 32'd0;
      r_maddr    <= 12'd0;
      r_mwe      <= 1'b0;
      r_mwdata   <= 32'd0;
    end else begin
      r_mwe  <= 1'b0;
      r_iack <= done & ~owner_d;
      r_dack <= done & owner_d;
      if (grant) begin
        owner_d  <= grant_d;
        owner_wr <= grant_d & w_dwe;
        cnt      <= 3'(MEM_LAT);
        r_maddr  <= grant_d ? w_daddr : w_iaddr;
        r_mwe    <= grant_d & w_dwe;
        if (grant_d) begin
          r_mwdata <= w_dwdata;
          if (!ireq_m)                             starve_cnt <= 4'd0;
          else if (starve_cnt != 4'(STARVE_MAX))   starve_cnt <= starve_cnt + 4'd1;
        end else begin
          starve_cnt <= 4'd0;
        end
      end else if (state == S_WAIT && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
      // Writes complete without touching the load-data register.
      if (done) begin
        if (!owner_d)       r_irdata <= w_mrdata;
        else if (!owner_wr) r_drdata <= w_mrdata;
      end
    end
  end

endmodule
